// File: rtl/shared_pkg.sv
// Shared definitions for the FIFO-to-SPI drain block.
//   drain_state_e     : drain FSM state encoding
//   FifoWidthDefault  : default FIFO word width / data bits per SPI frame
package shared_pkg;

  localparam int unsigned FifoWidthDefault = 16;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StShift,
    StGap
  } drain_state_e;

endpackage

// File: rtl/sclk_gen.sv
// SCLK half-period divider for the SPI drain.
// Counts clk cycles while enabled and emits a one-cycle toggle strobe every
// CLK_DIV cycles; the owner flips SCLK on each strobe.
//   clk    : clock
//   rst    : synchronous active-high reset
//   en     : divider enable; counter is held at zero while low
//   clr    : synchronous counter clear
//   toggle : one-cycle strobe, SCLK half-period elapsed
module sclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic toggle
);

  logic [7:0] cnt_q;

  assign toggle = en && (cnt_q == 8'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt_q <= '0;
    end else if (toggle) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/fifo_spi_drain.sv
// Drains words from a FIFO and sends each as one SPI mode-0 frame, MSB first.
// FSM: IDLE -> POP -> LOAD -> SHIFT -> GAP -> IDLE.
// Optional feature: define DRAIN_PARITY_EN to append one odd-parity bit after
// the data LSB inside the same frame.
//   clk, rst        : clock, synchronous active-high reset
//   en              : drain enable (checked only in IDLE)
//   fifo_empty      : FIFO empty flag
//   fifo_data_out   : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_underflow  : FIFO underflow flag
//   fifo_rd_en      : one-cycle pop strobe
//   sclk, mosi, ss_n: SPI outputs (sclk idles low, ss_n active low)
//   busy            : FSM not in IDLE
//   words_sent      : completed-frame counter (wraps)
//   underflow_err   : sticky underflow flag, cleared only by rst
module fifo_spi_drain
  import shared_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FifoWidthDefault,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  ss_n,
  output logic                  busy,
  output logic [15:0]           words_sent,
  output logic                  underflow_err
);

`ifdef DRAIN_PARITY_EN
  localparam int unsigned FrameBits = FIFO_WIDTH + 1;
`else
  localparam int unsigned FrameBits = FIFO_WIDTH;
`endif
  localparam int unsigned BitCntW = $clog2(FrameBits + 1);
  localparam int unsigned GapCntW = 4;

  drain_state_e         state_q, state_d;
  logic [FrameBits-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GapCntW-1:0]   gap_cnt_q, gap_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 ss_n_q, ss_n_d;
  logic [15:0]          words_q, words_d;
  logic                 underflow_q;
  logic                 div_toggle;
  logic [FrameBits-1:0] load_word;

`ifdef DRAIN_PARITY_EN
  // Odd parity: the parity bit makes the total count of ones odd.
  assign load_word = {fifo_data_out, ~^fifo_data_out};
`else
  assign load_word = fifo_data_out;
`endif

  sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == StShift),
    .clr   (state_q == StLoad),
    .toggle(div_toggle)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    ss_n_d    = ss_n_q;
    words_d   = words_q;

    unique case (state_q)
      StIdle: begin
        if (en && !fifo_empty) begin
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StLoad;
      end
      StLoad: begin
        shift_d   = load_word;
        ss_n_d    = 1'b0;
        sclk_d    = 1'b0;
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        if (div_toggle) begin
          sclk_d = ~sclk_q;
          // sclk currently high: this toggle is a falling edge
          if (sclk_q) begin
            shift_d = {shift_q[FrameBits-2:0], 1'b0};
            if (bit_cnt_q == BitCntW'(FrameBits - 1)) begin
              state_d   = StGap;
              ss_n_d    = 1'b1;
              words_d   = words_q + 16'd1;
              gap_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapCntW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      words_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      words_q     <= words_d;
      underflow_q <= underflow_q | fifo_underflow;
    end
  end

  assign fifo_rd_en    = (state_q == StPop);
  assign sclk          = sclk_q;
  assign mosi          = (state_q == StShift) && shift_q[FrameBits-1];
  assign ss_n          = ss_n_q;
  assign busy          = (state_q != StIdle);
  assign words_sent    = words_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_fifo_spi_drain.sv
`timescale 1ns/1ps
module tb_fifo_spi_drain;

  localparam int unsigned W          = 16;
  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned GAP_CYCLES = 2;
`ifdef DRAIN_PARITY_EN
  localparam int unsigned FRAME_BITS = W + 1;
`else
  localparam int unsigned FRAME_BITS = W;
`endif
  localparam int unsigned FRAME_CYCLES = 2 * CLK_DIV * FRAME_BITS;
  localparam int          TIMEOUT      = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_underflow = 1'b0;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_rd_en, sclk, mosi, ss_n, busy, underflow_err;
  logic [15:0]   words_sent;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  fifo_q[$];
  logic [16:0]   exp_q[$];
  int            exp_pops = 0;
  int            exp_words = 0;

  typedef struct {
    logic [15:0] word;
    logic        par;  // odd-parity bit, worked out by hand
  } vec_t;
  vec_t vecs[6];

  fifo_spi_drain #(
    .FIFO_WIDTH(W),
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .sclk          (sclk),
    .mosi          (mosi),
    .ss_n          (ss_n),
    .busy          (busy),
    .words_sent    (words_sent),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: data appears the cycle after the pop strobe.
  always @(negedge clk) begin
    if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) begin
      fifo_data_out = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic push(input logic [15:0] w, input logic par);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
    exp_q.push_back(FRAME_BITS > W ? {w, par} : {1'b0, w});
    exp_pops++;
  endtask

  // Monitor / scoreboard
  logic        empty_s = 1'b1;
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        have_end = 1'b0;
  logic        abort_pending = 1'b0;
  int          bit_n = 0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          rd_cnt = 0;
  logic [16:0] frame_acc = '0;
  logic [16:0] e;

  always @(posedge clk) empty_s <= fifo_empty;

  always @(negedge clk) begin
    if (rst) begin
      if (abort_pending && exp_q.size() > 0) void'(exp_q.pop_front());
      abort_pending = 1'b0;
      prev_ss = 1'b1;
      prev_sclk = 1'b0;
      have_end = 1'b0;
      bit_n = 0;
      frame_acc = '0;
      low_cnt = 0;
      high_cnt = 0;
    end else begin
      if (fifo_rd_en === 1'b1) begin
        rd_cnt++;
        check("rd_en_after_nonempty", {31'd0, empty_s}, 32'd0);
      end
      if (ss_n === 1'b0 && prev_ss) begin
        if (have_end) check("ss_n_gap_ok", {31'd0, high_cnt >= GAP_CYCLES + 2}, 32'd1);
        low_cnt = 1;
        bit_n = 0;
        frame_acc = '0;
      end else if (ss_n === 1'b0) begin
        low_cnt++;
      end
      if (ss_n === 1'b0 && sclk === 1'b1 && !prev_sclk) begin
        frame_acc = {frame_acc[15:0], mosi};
        bit_n++;
      end
      if (ss_n === 1'b1 && !prev_ss) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got frame %0h expected none", frame_acc);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", bit_n, FRAME_BITS);
          check("frame_data", {15'd0, frame_acc}, {15'd0, e});
          check("ss_n_low_cycles", low_cnt, FRAME_CYCLES);
        end
        have_end = 1'b1;
        high_cnt = 1;
      end else if (ss_n === 1'b1) begin
        high_cnt++;
      end
      prev_ss = (ss_n === 1'b1);
      prev_sclk = (sclk === 1'b1);
    end
  end

  task automatic wait_words(input int n);
    int t = 0;
    while (words_sent !== 16'(n) && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check("words_sent", {16'd0, words_sent}, n);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // Wait until a new frame is shifting and n rising sclk edges have been seen.
  task automatic wait_bits(input int n);
    int t = 0;
    while (ss_n !== 1'b0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    while (bit_n < n && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check("reached_sclk_edge", {31'd0, bit_n >= n}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    check({tag, "_sclk"}, {31'd0, sclk}, 32'd0);
    check({tag, "_mosi"}, {31'd0, mosi}, 32'd0);
    check({tag, "_ss_n"}, {31'd0, ss_n}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_words"}, {16'd0, words_sent}, 32'd0);
  endtask

  initial begin
    int viol;
    vecs[0] = '{16'hA5C3, 1'b1};
    vecs[1] = '{16'hFFFF, 1'b1};
    vecs[2] = '{16'h0000, 1'b1};
    vecs[3] = '{16'h1234, 1'b0};
    vecs[4] = '{16'h0003, 1'b1};
    vecs[5] = '{16'h0007, 1'b0};

    // Reset state
    rst = 1'b1;
    fifo_underflow = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_underflow_err", {31'd0, underflow_err}, 32'd0);
    fifo_underflow = 1'b0;
    rst = 1'b0;
    en = 1'b1;

    // Single words from the table
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].word, vecs[i].par);
      exp_words++;
      wait_words(exp_words);
      wait_idle();
      check("rd_en_pulses", rd_cnt, exp_pops);
    end

    // Back-to-back words
    push(16'h0001, 1'b0);
    push(16'h8000, 1'b0);
    exp_words += 2;
    wait_words(exp_words);
    wait_idle();
    check("b2b_rd_en_pulses", rd_cnt, exp_pops);

    // Reset after the 5th rising sclk edge: frame aborted, word lost
    push(16'h5A5A, 1'b1);
    wait_bits(5);
    abort_pending = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    exp_words = 0;
    repeat (3) @(negedge clk);
    push(16'h3C3C, 1'b1);
    exp_words = 1;
    wait_words(exp_words);
    wait_idle();
    check("post_reset_rd_en_pulses", rd_cnt, exp_pops);

    // en dropped mid-frame with three words queued
    push(16'h1111, 1'b1);
    push(16'h2222, 1'b1);
    push(16'h4444, 1'b1);
    wait_bits(3);
    en = 1'b0;
    wait_words(exp_words + 1);
    repeat (100) @(negedge clk);
    check("en_low_rd_en_pulses", rd_cnt, exp_pops - 2);
    check("en_low_busy", {31'd0, busy}, 32'd0);
    check("en_low_words", {16'd0, words_sent}, exp_words + 1);
    en = 1'b1;
    exp_words += 3;
    wait_words(exp_words);
    wait_idle();
    check("resume_rd_en_pulses", rd_cnt, exp_pops);

    // Underflow is sticky; empty FIFO never pops
    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    check("underflow_set", {31'd0, underflow_err}, 32'd1);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("empty_no_pop", viol, 0);
    check("underflow_sticky", {31'd0, underflow_err}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("underflow_cleared", {31'd0, underflow_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
